// File: rtl/ram16k_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram16k_arbiter
// Description : Two-master arbiter for the single-port 16K x 16 data RAM.
//               Port A (CPU) has priority. Port B is protected from starvation
//               by a wait counter and may hold the RAM for bounded lock bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module ram16k_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4,
    parameter int LOCK_MAX   = 8
) (
    input  logic              clock,
    input  logic              aclr_n,
    // Port A (priority master)
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_stall,
    output logic [DATA_W-1:0] a_rdata,
    // Port B (secondary master)
    input  logic              b_req,
    input  logic              b_we,
    input  logic              b_lock,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_forced,
    // RAM interface
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    output logic              ram_aclr,
    input  logic [DATA_W-1:0] ram_q
);

    localparam logic [7:0] C_STARVE_MAX = 8'(STARVE_MAX);
    localparam logic [7:0] C_LOCK_LAST  = 8'(LOCK_MAX - 1);

    logic [7:0] wcnt_q, wcnt_d;
    logic       lock_q, lock_d;
    logic [7:0] lcnt_q, lcnt_d;

    logic       w_lock_hit;
    logic       w_starved;
    logic       w_b_win;

    // The RAM read port is asynchronous, so both masters see q directly.
    assign a_rdata  = ram_q;
    assign b_rdata  = ram_q;
    assign ram_aclr = 1'b0;
    assign a_stall  = a_req && !a_gnt;

    // Priority decode: lock owner, then starved B, then A, then idle-A B.
    // Grants are gated by aclr_n so nothing is issued while reset is held.
    always_comb begin
        w_lock_hit = lock_q && b_req;
        w_starved  = b_req && (wcnt_q == C_STARVE_MAX);
        w_b_win    = w_lock_hit || w_starved || (b_req && !a_req);
        b_gnt      = aclr_n && w_b_win;
        a_gnt      = aclr_n && a_req && !w_b_win;
        b_forced   = aclr_n && w_starved && !w_lock_hit;
    end

    // RAM mux follows the winner; with no grant A's bus is presented, write off.
    always_comb begin
        ram_address = a_addr;
        ram_data    = a_wdata;
        ram_wren    = 1'b0;
        if (b_gnt) begin
            ram_address = b_addr;
            ram_data    = b_wdata;
            ram_wren    = b_we;
        end else if (a_gnt) begin
            ram_wren    = a_we;
        end
    end

    // Next-state for the starvation counter and the lock burst tracker.
    always_comb begin
        wcnt_d = wcnt_q;
        lock_d = lock_q;
        lcnt_d = lcnt_q;

        if (b_gnt) begin
            wcnt_d = 8'd0;
        end else if (b_req) begin
            wcnt_d = (wcnt_q == C_STARVE_MAX) ? wcnt_q : wcnt_q + 8'd1;
        end else begin
            wcnt_d = 8'd0;
        end

        if (b_gnt) begin
            // The final locked grant clears the lock so A can win next cycle.
            if (b_lock && (lcnt_q < C_LOCK_LAST)) begin
                lock_d = 1'b1;
                lcnt_d = lcnt_q + 8'd1;
            end else begin
                lock_d = 1'b0;
                lcnt_d = 8'd0;
            end
        end else if (!b_req) begin
            // Requester dropped out: release ownership.
            lock_d = 1'b0;
            lcnt_d = 8'd0;
        end
    end

    // State register with asynchronous active-low clear.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            wcnt_q <= 8'd0;
            lock_q <= 1'b0;
            lcnt_q <= 8'd0;
        end else begin
            wcnt_q <= wcnt_d;
            lock_q <= lock_d;
            lcnt_q <= lcnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram16k_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram16k_arbiter
// Description : Directed self-checking bench for ram16k_arbiter with a
//               behavioural 16K x 16 RAM (async read, write on rising edge).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram16k_arbiter;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 16;

    logic              clock;
    logic              aclr_n;
    logic              a_req, a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt, a_stall;
    logic [DATA_W-1:0] a_rdata;
    logic              b_req, b_we, b_lock;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt, b_forced;
    logic [DATA_W-1:0] b_rdata;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren, ram_aclr;
    logic [DATA_W-1:0] ram_q;

    // Preload port into the RAM model, used only while the DUT is in reset
    logic              pre_we;
    logic [ADDR_W-1:0] pre_addr;
    logic [DATA_W-1:0] pre_data;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int tests;
    int fails;

    ram16k_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4), .LOCK_MAX(8)
    ) dut (
        .clock(clock), .aclr_n(aclr_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_stall(a_stall), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_gnt(b_gnt), .b_rdata(b_rdata), .b_forced(b_forced),
        .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
        .ram_aclr(ram_aclr), .ram_q(ram_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural RAM
    assign ram_q = mem[ram_address];
    always @(posedge clock) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (ram_wren)
            mem[ram_address] <= ram_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        @(negedge clock);
        pre_we   = 1'b1;
        pre_addr = addr;
        pre_data = data;
        @(negedge clock);
        pre_we   = 1'b0;
    endtask

    initial begin
        tests = 0; fails = 0;
        pre_we = 0; pre_addr = '0; pre_data = '0;
        aclr_n = 0;
        a_req = 1; a_we = 0; a_addr = 14'h0010; a_wdata = 16'h0;
        b_req = 1; b_we = 0; b_lock = 0; b_addr = 14'h0020; b_wdata = 16'h0;

        // ---- Reset state, with both masters requesting
        preload(14'h0010, 16'h1234);
        preload(14'h0100, 16'h5555);
        preload(14'h3FFF, 16'h0000);
        #1;
        check("rst_a_gnt",   a_gnt, 0);
        check("rst_b_gnt",   b_gnt, 0);
        check("rst_wren",    ram_wren, 0);
        check("rst_forced",  b_forced, 0);
        check("rst_addr",    ram_address, 14'h0010);
        check("rst_aclr",    ram_aclr, 0);

        // ---- A reads 0x0010, B idle
        @(negedge clock);
        aclr_n = 1; b_req = 0;
        #1;
        check("ard_a_gnt",   a_gnt, 1);
        check("ard_rdata",   a_rdata, 16'h1234);
        check("ard_b_gnt",   b_gnt, 0);
        check("ard_wren",    ram_wren, 0);
        check("ard_stall",   a_stall, 0);

        // ---- A writes 0x3FFF <- 0xBEEF, then B reads it back
        @(negedge clock);
        a_we = 1; a_addr = 14'h3FFF; a_wdata = 16'hBEEF;
        #1;
        check("awr_a_gnt",   a_gnt, 1);
        check("awr_wren",    ram_wren, 1);
        check("awr_addr",    ram_address, 14'h3FFF);
        check("awr_data",    ram_data, 16'hBEEF);
        @(negedge clock);
        a_req = 0; a_we = 0;
        b_req = 1; b_addr = 14'h3FFF;
        #1;
        check("brd_b_gnt",   b_gnt, 1);
        check("brd_rdata",   b_rdata, 16'hBEEF);
        check("brd_forced",  b_forced, 0);
        check("brd_addr",    ram_address, 14'h3FFF);

        // ---- Both requesting: A,A,A,A,B repeating
        @(negedge clock);
        a_req = 1; a_addr = 14'h0010; b_addr = 14'h0020;
        for (int i = 0; i < 10; i++) begin
            if (i != 0) @(negedge clock);
            #1;
            check($sformatf("starve_a_gnt%0d", i),  a_gnt,    (i % 5 != 4));
            check($sformatf("starve_b_gnt%0d", i),  b_gnt,    (i % 5 == 4));
            check($sformatf("starve_forced%0d", i), b_forced, (i % 5 == 4));
            check($sformatf("starve_stall%0d", i),  a_stall,  (i % 5 == 4));
        end

        // ---- Forced grant with lock: 8 consecutive B grants, then A
        @(negedge clock);
        b_lock = 1;
        for (int i = 0; i < 13; i++) begin
            if (i != 0) @(negedge clock);
            #1;
            check($sformatf("lock_b_gnt%0d", i),  b_gnt,    (i >= 4 && i <= 11));
            check($sformatf("lock_a_gnt%0d", i),  a_gnt,    !(i >= 4 && i <= 11));
            check($sformatf("lock_forced%0d", i), b_forced, (i == 4));
        end

        // ---- Idle cycle: no grant, A bus presented
        @(negedge clock);
        a_req = 0; b_req = 0; b_lock = 0; a_addr = 14'h0033; a_wdata = 16'h7777;
        #1;
        check("idle_a_gnt",  a_gnt, 0);
        check("idle_b_gnt",  b_gnt, 0);
        check("idle_addr",   ram_address, 14'h0033);
        check("idle_data",   ram_data, 16'h7777);
        check("idle_wren",   ram_wren, 0);

        // ---- Lock reaching lcnt=3, then B drops for one cycle
        @(negedge clock);
        a_req = 1; a_addr = 14'h0010; b_req = 1; b_lock = 1;
        for (int i = 0; i < 10; i++) begin
            if (i != 0) @(negedge clock);
            if (i == 7) b_req = 0;
            if (i == 8) b_req = 1;
            #1;
            check($sformatf("drop_b_gnt%0d", i), b_gnt, (i >= 4 && i <= 6));
            check($sformatf("drop_a_gnt%0d", i), a_gnt, !(i >= 4 && i <= 6));
        end

        // Clear the wait counter
        @(negedge clock);
        a_req = 0; b_req = 0; b_lock = 0;

        // ---- Reset pulse mid-lock during a B write to 0x0100
        @(negedge clock);
        a_req = 1; b_req = 1; b_lock = 1; b_we = 0; b_addr = 14'h0200;
        for (int i = 0; i < 6; i++) begin
            if (i != 0) @(negedge clock);
            #1;
            check($sformatf("mid_b_gnt%0d", i), b_gnt, (i >= 4));
        end
        @(negedge clock);
        b_we = 1; b_addr = 14'h0100; b_wdata = 16'hAAAA;
        #1;
        check("mid_wr_b_gnt", b_gnt, 1);
        check("mid_wr_wren",  ram_wren, 1);
        aclr_n = 0;
        #1;
        check("rstp_b_gnt",  b_gnt, 0);
        check("rstp_a_gnt",  a_gnt, 0);
        check("rstp_wren",   ram_wren, 0);
        check("rstp_forced", b_forced, 0);
        @(negedge clock);
        aclr_n = 1;
        #1;
        check("post_a_gnt",  a_gnt, 1);
        check("post_b_gnt",  b_gnt, 0);
        @(negedge clock);
        b_req = 0; b_we = 0; b_lock = 0; a_addr = 14'h0100;
        #1;
        check("post_rdata",  a_rdata, 16'h5555);
        check("post_a_gnt2", a_gnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Bound on total simulation time
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/ram16k_arbiter.md
Name: ram16k_arbiter

Overview:
- Two-port arbiter sharing the single-port 16K x 16 Hack data RAM between the CPU (port A) and a secondary master such as screen DMA or a block-copy engine (port B).
- Port A has priority.
- Port B is protected by a starvation counter and may lock the RAM for bounded bursts.
- Sits between the requesters and the RAM instance, driving its address/data/wren interface and returning its asynchronous read data.

Parameters:
- ADDR_W, 14, RAM address width.
- DATA_W, 16, RAM data width.
- STARVE_MAX, 4, consecutive denied cycles for B before B is forced a grant (1..255).
- LOCK_MAX, 8, maximum consecutive locked grants for B (1..255).

Ports:
- clock  in  1  system clock, all state on rising edge.
- aclr_n  in  1  asynchronous active-low reset.
- a_req  in  1  port A access request.
- a_we  in  1  port A write enable (qualifies a_req).
- a_addr  in  ADDR_W  port A address.
- a_wdata  in  DATA_W  port A write data.
- a_gnt  out  1  port A granted this cycle.
- a_stall  out  1  a_req && !a_gnt.
- a_rdata  out  DATA_W  read data; valid when a_gnt && !a_we.
- b_req  in  1  port B access request.
- b_we  in  1  port B write enable.
- b_lock  in  1  B requests to keep ownership after this access.
- b_addr  in  ADDR_W  port B address.
- b_wdata  in  DATA_W  port B write data.
- b_gnt  out  1  port B granted this cycle.
- b_rdata  out  DATA_W  read data; valid when b_gnt && !b_we.
- ram_address  out  ADDR_W  to RAM address.
- ram_data  out  DATA_W  to RAM data.
- ram_wren  out  1  to RAM wren.
- ram_aclr  out  1  to RAM aclr; constant 0.
- ram_q  in  DATA_W  from RAM q (combinational read).
- b_forced  out  1  current B grant was forced by starvation.

Behaviour:
- State registers:
  - wcnt: B wait counter, 8 bit.
  - lock_q: B owns the RAM.
  - lcnt: locked grant count, 8 bit.
- All state registers clear asynchronously while aclr_n = 0.
- During reset all grants, ram_wren and b_forced are 0. ram_address = a_addr, ram_data = a_wdata.
- Grant priority is combinational from the inputs and registered state. The first matching rule wins:
  1. lock_q && b_req -> B.
  2. b_req && wcnt == STARVE_MAX -> B (b_forced = 1).
  3. a_req -> A.
  4. b_req -> B.
  5. Otherwise no grant.
- Exactly one of a_gnt/b_gnt may be 1 in any cycle.
- Mux:
  - ram_address, ram_data and ram_wren follow the winner; ram_wren = winner's we.
  - With no grant: ram_address = a_addr, ram_data = a_wdata, ram_wren = 0.
- Latency:
  - Reads return in the grant cycle: a_rdata = b_rdata = ram_q, unconditionally wired.
  - Writes commit at the rising edge ending the grant cycle.
  - A write followed next cycle by a read of the same address returns the new data.
- wcnt update at each edge:
  - b_gnt -> 0.
  - b_req && !b_gnt -> wcnt + 1, saturating at STARVE_MAX.
  - !b_req -> 0.
- lock_q/lcnt update at each edge:
  - b_gnt && b_lock && lcnt < LOCK_MAX-1 -> lock_q = 1, lcnt + 1.
  - b_gnt && b_lock && lcnt == LOCK_MAX-1 -> lock_q = 0, lcnt = 0. Lock expires; A wins next cycle if a_req.
  - b_gnt && !b_lock -> lock_q = 0, lcnt = 0.
  - !b_req while lock_q -> lock_q = 0, lcnt = 0. Requester dropped.
- Boundaries:
  - A continuously requesting: B is granted exactly once every STARVE_MAX+1 cycles.
  - Lock cannot be extended beyond LOCK_MAX consecutive cycles.
  - A forced grant with b_lock = 1 starts a lock; lcnt counts from that grant.
  - Reset asserted mid-burst: lock and counters drop immediately; any write in progress is not committed if aclr_n is low at the edge.
  - Requesters must hold req/addr/data stable until granted. The arbiter never latches request data.

Test Plan:
- Reset, then A reads 0x0010 (preloaded 0x1234), B idle -> a_gnt = 1 the same cycle, a_rdata = 0x1234, b_gnt = 0, ram_wren = 0.
- A writes 0x3FFF <- 0xBEEF in cycle n; B reads 0x3FFF in cycle n+1 -> b_gnt = 1, b_rdata = 0xBEEF.
- a_req and b_req both held high (STARVE_MAX = 4) -> grant pattern A,A,A,A,B repeating. b_forced = 1 on each B cycle; a_stall = 1 on each B cycle.
- B with b_lock = 1 held, a_req high (LOCK_MAX = 8), B granted via starvation -> 8 consecutive b_gnt, then a_gnt the next cycle.
- B locked with lcnt = 3, b_req drops for one cycle while a_req is high -> a_gnt in that cycle; lock_q = 0 afterwards; A keeps priority.
- aclr_n pulsed low mid-lock during a B write to 0x0100 -> gnts and ram_wren = 0 immediately, 0x0100 unchanged; after release A wins the first contested cycle.
